// File: rtl/avalon_packet_arbiter_pkg.sv
// Shared types and helpers for the Avalon-ST packet arbiter.
//   arb_state_t : arbiter FSM states
//   rr_pick     : round-robin index selection from a request vector and the last grant
package avalon_arbiter_pack;

  // Upper bound on the number of sources rr_pick can scan.
  localparam int unsigned MAX_SRC = 32;

  typedef enum logic [1:0] {IDLE, LOCKED, CLOSE, DRAIN} arb_state_t;

  // First set bit of req scanning upward from last+1, wrapping at n. Returns last when req is
  // empty. The loop has a constant bound so it unrolls in synthesis.
  function automatic int unsigned rr_pick(input logic [MAX_SRC-1:0] req,
                                          input int unsigned        last,
                                          input int unsigned        n);
    int unsigned idx;
    logic        found;
    rr_pick = last;
    found   = 1'b0;
    for (int unsigned k = 1; k <= MAX_SRC; k++) begin
      if (!found && (k <= n)) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[$clog2(MAX_SRC)-1:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req_i  : request vector, one bit per source
//   last_i : previously granted index; the scan starts just above it
//   pick_o : winning index (equals last_i when nothing requests)
module rr_arbiter
  import avalon_arbiter_pack::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req_i,
  input  logic [$clog2(NUM_SRC)-1:0] last_i,
  output logic [$clog2(NUM_SRC)-1:0] pick_o
);

  localparam int unsigned GW = $clog2(NUM_SRC);

  logic [MAX_SRC-1:0] req_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_SRC-1:0]   = req_i;
    pick_o                 = GW'(rr_pick(req_ext, 32'(last_i), NUM_SRC));
  end

endmodule

// File: rtl/avalon_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one Avalon-ST output among NUM_SRC sources.
// The grant is held from sop to eop so packets never interleave; non-sop beats offered while
// idle are discarded so a broken source cannot wedge the output.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   in_valid_i/in_sop_i/in_eop_i      per-source sideband, one bit per source
//   in_data_i/in_empty_i              per-source payload, source i at [i*W +: W]
//   in_ready_o                        per-source ready
//   out_valid_o/out_sop_o/out_eop_o   output sideband
//   out_data_o/out_empty_o            output payload (empty is 0 except on eop)
//   out_ready_i                       output backpressure
//   grant_id_o                        current/last granted source
//   busy_o                            a packet holds the grant
//   orphan_drop_o                     1-cycle pulse per discarded orphan beat
//   timeout_err_o                     1-cycle pulse on a forced packet close
// Optional feature: define AVALON_ARB_TIMEOUT_EN to close packets whose source stalls for
// TIMEOUT_CYCLES cycles mid-packet and drain the rest of that packet.
module avalon_packet_arbiter
  import avalon_arbiter_pack::*;
#(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned EMPTY_WIDTH    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_SRC-1:0]             in_valid_i,
  input  logic [NUM_SRC-1:0]             in_sop_i,
  input  logic [NUM_SRC-1:0]             in_eop_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  in_data_i,
  input  logic [NUM_SRC*EMPTY_WIDTH-1:0] in_empty_i,
  output logic [NUM_SRC-1:0]             in_ready_o,
  output logic                           out_valid_o,
  output logic                           out_sop_o,
  output logic                           out_eop_o,
  output logic [DATA_WIDTH-1:0]          out_data_o,
  output logic [EMPTY_WIDTH-1:0]         out_empty_o,
  input  logic                           out_ready_i,
  output logic [$clog2(NUM_SRC)-1:0]     grant_id_o,
  output logic                           busy_o,
  output logic [NUM_SRC-1:0]             orphan_drop_o,
  output logic                           timeout_err_o
);

  localparam int unsigned GW = $clog2(NUM_SRC);

  arb_state_t              state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d, pick;
  logic [NUM_SRC-1:0]      req, orphan;
  logic [DATA_WIDTH-1:0]   data_arr  [NUM_SRC];
  logic [EMPTY_WIDTH-1:0]  empty_arr [NUM_SRC];
  logic                    stall_hit;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign data_arr[i]  = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign empty_arr[i] = in_empty_i[i*EMPTY_WIDTH +: EMPTY_WIDTH];
  end

  assign req    = in_valid_i & in_sop_i;
  assign orphan = in_valid_i & ~in_sop_i;

  rr_arbiter #(
    .NUM_SRC(NUM_SRC)
  ) u_rr (
    .req_i (req),
    .last_i(grant_q),
    .pick_o(pick)
  );

`ifdef AVALON_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] stall_q, stall_d;

  // Counts only cycles where the granted source offers nothing; backpressure does not count.
  always_comb begin
    stall_d = '0;
    if (state_q == LOCKED) begin
      if (in_valid_i[grant_q] && out_ready_i) stall_d = '0;
      else if (!in_valid_i[grant_q])          stall_d = stall_q + 1'b1;
      else                                    stall_d = stall_q;
    end
  end

  assign stall_hit = (state_q == LOCKED) && !in_valid_i[grant_q] &&
                     (stall_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  localparam int unsigned UnusedTimeoutCycles = TIMEOUT_CYCLES;
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    in_ready_o    = '0;
    orphan_drop_o = '0;
    out_valid_o   = 1'b0;
    out_sop_o     = 1'b0;
    out_eop_o     = 1'b0;
    out_data_o    = '0;
    out_empty_o   = '0;
    timeout_err_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Orphans are swallowed; sop requesters wait one bubble cycle for the grant.
        in_ready_o    = orphan;
        orphan_drop_o = orphan;
        if (|req) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        out_valid_o         = in_valid_i[grant_q];
        out_sop_o           = in_sop_i[grant_q];
        out_eop_o           = in_eop_i[grant_q];
        out_data_o          = data_arr[grant_q];
        if (in_eop_i[grant_q]) out_empty_o = empty_arr[grant_q];
        in_ready_o[grant_q] = out_ready_i;
        if (in_valid_i[grant_q] && out_ready_i && in_eop_i[grant_q]) state_d = IDLE;
        else if (stall_hit)                                          state_d = CLOSE;
      end
`ifdef AVALON_ARB_TIMEOUT_EN
      CLOSE: begin
        // Synthetic eop so downstream sees a terminated packet.
        out_valid_o = 1'b1;
        out_eop_o   = 1'b1;
        if (out_ready_i) begin
          timeout_err_o = 1'b1;
          state_d       = DRAIN;
        end
      end
      DRAIN: begin
        in_ready_o[grant_q] = 1'b1;
        if (in_valid_i[grant_q] && in_eop_i[grant_q]) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    // State is already IDLE during reset; this keeps the idle-state drop path quiet too.
    if (rst_i) begin
      in_ready_o    = '0;
      orphan_drop_o = '0;
      timeout_err_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= GW'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_avalon_packet_arbiter.sv
// Self-checking bench for avalon_packet_arbiter (default build, timeout feature off).
module tb_avalon_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int EW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    v, s, e;
  logic [N*DW-1:0] d;
  logic [N*EW-1:0] em;
  logic            ordy;

  logic [N-1:0]    rdy, drop;
  logic            ov, os, oe, busy, terr;
  logic [DW-1:0]   od;
  logic [EW-1:0]   oem;
  logic [1:0]      gid;

  avalon_packet_arbiter #(
    .NUM_SRC       (N),
    .DATA_WIDTH    (DW),
    .EMPTY_WIDTH   (EW),
    .TIMEOUT_CYCLES(256)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (v),
    .in_sop_i     (s),
    .in_eop_i     (e),
    .in_data_i    (d),
    .in_empty_i   (em),
    .in_ready_o   (rdy),
    .out_valid_o  (ov),
    .out_sop_o    (os),
    .out_eop_o    (oe),
    .out_data_o   (od),
    .out_empty_o  (oem),
    .out_ready_i  (ordy),
    .grant_id_o   (gid),
    .busy_o       (busy),
    .orphan_drop_o(drop),
    .timeout_err_o(terr)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which source (if any) owns the output, and the last winner.
  bit m_lock;
  int m_g;

  logic [N-1:0]  last_hs;
  logic [N-1:0]  cap_rdy, cap_drop;
  logic          cap_ov, cap_oe, cap_busy;
  logic [DW-1:0] cap_od;
  logic [EW-1:0] cap_oem;
  logic [1:0]    cap_gid;

  bit            sb_on;
  int            sb_beat;
  int            sop_order[$];
  logic [DW-1:0] out_log[$];

  // Random source generator state.
  int g_mode;
  int g_len[N], g_beat[N], g_pkt[N];
  bit g_act[N], g_orph[N], g_hold[N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at posedge+1 with inputs applied; samples mid-cycle, then advances one clock.
  task automatic step();
    logic [N-1:0]  x_rdy, x_drop;
    logic          x_ov, x_os, x_oe;
    logic [DW-1:0] x_od;
    logic [EW-1:0] x_oem;
    bit            any;
    int            win;
    x_rdy = '0; x_drop = '0; x_ov = 0; x_os = 0; x_oe = 0; x_od = '0; x_oem = '0;
    any = 0; win = 0;
    #3;
    if (!rst) begin
      if (!m_lock) begin
        x_rdy  = v & ~s;
        x_drop = v & ~s;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_g + k) % N;
          if (!any && v[c] && s[c]) begin
            any = 1;
            win = c;
          end
        end
      end else begin
        x_ov       = v[m_g];
        x_os       = s[m_g];
        x_oe       = e[m_g];
        x_od       = d[m_g*DW +: DW];
        x_oem      = e[m_g] ? em[m_g*EW +: EW] : '0;
        x_rdy[m_g] = ordy;
      end
    end
    chk("in_ready", rdy, x_rdy);
    chk("orphan_drop", drop, x_drop);
    chk("out_valid", ov, x_ov);
    chk("out_sop", os, x_os);
    chk("out_eop", oe, x_oe);
    chk("out_data", od, x_od);
    chk("out_empty", oem, x_oem);
    chk("grant_id", gid, rst ? N - 1 : m_g);
    chk("busy", busy, rst ? 0 : m_lock);
    chk("timeout_err", terr, 0);
    cap_rdy = rdy; cap_drop = drop; cap_ov = ov; cap_oe = oe; cap_busy = busy;
    cap_od = od; cap_oem = oem; cap_gid = gid;
    if (ov && ordy && !rst) begin
      out_log.push_back(od);
      if (os) sop_order.push_back(int'(gid));
      if (sb_on) begin
        // Packet integrity: every beat carries the locked source id and consecutive indices.
        if (os) sb_beat = 0;
        chk("sb src", od[31:24], m_g);
        chk("sb beat", od[7:0], sb_beat);
        sb_beat++;
      end
    end
    last_hs = v & x_rdy;
    @(posedge clk);
    if (rst) begin
      m_lock = 0;
      m_g    = N - 1;
    end else if (!m_lock) begin
      if (any) begin
        m_lock = 1;
        m_g    = win;
      end
    end else if (x_ov && ordy && x_oe) begin
      m_lock = 0;
    end
    #1;
  endtask

  task automatic put(input int i, input bit vv, input bit ss, input bit ee,
                     input logic [DW-1:0] dd);
    v[i]            = vv;
    s[i]            = ss;
    e[i]            = ee;
    d[i*DW +: DW]   = dd;
    em[i*EW +: EW]  = dd[EW-1:0];
  endtask

  task automatic clear_inputs();
    v = '0; s = '0; e = '0; d = '0; em = '0;
  endtask

  task automatic gen_init();
    for (int i = 0; i < N; i++) begin
      g_act[i] = 0; g_hold[i] = 0; g_beat[i] = 0; g_len[i] = 1; g_pkt[i] = 0; g_orph[i] = 0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    gen_init();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  // Mode 1: random packets, gaps and orphans. Mode 2: back-to-back 2-beat packets.
  task automatic gen_drive();
    for (int i = 0; i < N; i++) begin
      if (!g_act[i] && (g_mode == 2 || $urandom_range(0, 2) == 0)) begin
        g_act[i]  = 1;
        g_beat[i] = 0;
        g_pkt[i]++;
        g_len[i]  = (g_mode == 2) ? 2 : int'($urandom_range(1, 4));
        g_orph[i] = (g_mode != 2) && ($urandom_range(0, 5) == 0);
        g_hold[i] = 0;
      end
      if (!g_act[i])                     v[i] = 0;
      else if (g_hold[i] || g_mode == 2) v[i] = 1;
      else                               v[i] = ($urandom_range(0, 3) != 0);
      s[i]              = g_act[i] && (g_beat[i] == 0) && !g_orph[i];
      e[i]              = g_act[i] && (g_beat[i] == g_len[i] - 1);
      d[i*DW +: DW]     = {8'(i), 8'(g_pkt[i]), 8'h00, 8'(g_beat[i])};
      em[i*EW +: EW]    = 2'(g_pkt[i] + g_beat[i]);
      g_hold[i]         = v[i];
    end
  endtask

  task automatic gen_advance();
    for (int i = 0; i < N; i++) begin
      if (v[i] && last_hs[i]) begin
        g_hold[i] = 0;
        g_beat[i]++;
        if (g_beat[i] >= g_len[i]) g_act[i] = 0;
      end
    end
  endtask

  initial begin
    rst = 1; ordy = 0; sb_on = 0; g_mode = 0; sb_beat = 0;
    m_lock = 0; m_g = N - 1; last_hs = '0;
    clear_inputs();
    gen_init();
    @(posedge clk);
    #1;

    // Reset: an orphan offered during reset must be neither accepted nor dropped.
    put(3, 1, 0, 0, 32'h55);
    ordy = 1;
    step();
    chk("rst in_ready", cap_rdy, 0);
    chk("rst orphan_drop", cap_drop, 0);
    chk("rst grant_id", cap_gid, 3);
    chk("rst busy", cap_busy, 0);
    chk("rst out_valid", cap_ov, 0);
    clear_inputs();
    step();
    rst = 0;

    // Single 3-beat packet from source 1.
    put(1, 1, 1, 0, 32'hA1);
    step();
    chk("t1 bubble out_valid", cap_ov, 0);
    chk("t1 bubble ready", cap_rdy[1], 0);
    step();
    chk("t1 beat1 data", cap_od, 32'hA1);
    chk("t1 grant", cap_gid, 1);
    chk("t1 beat1 empty", cap_oem, 0);
    put(1, 1, 0, 0, 32'hA2);
    step();
    chk("t1 beat2 data", cap_od, 32'hA2);
    put(1, 1, 0, 1, 32'hA3);
    step();
    chk("t1 eop", cap_oe, 1);
    chk("t1 eop empty", cap_oem, 3);
    clear_inputs();
    step();
    chk("t1 idle busy", cap_busy, 0);

    // Orphan beat while idle.
    put(3, 1, 0, 0, 32'h55);
    step();
    chk("t4 ready", cap_rdy[3], 1);
    chk("t4 drop", cap_drop[3], 1);
    chk("t4 out_valid", cap_ov, 0);
    clear_inputs();

    // Backpressure mid-packet on source 2.
    out_log.delete();
    put(2, 1, 1, 0, 32'hC0);
    step();
    step();
    put(2, 1, 0, 0, 32'hC1);
    ordy = 0;
    repeat (5) begin
      step();
      chk("t3 stalled ready", cap_rdy[2], 0);
    end
    ordy = 1;
    step();
    put(2, 1, 0, 0, 32'hC2);
    step();
    put(2, 1, 0, 1, 32'hC3);
    step();
    clear_inputs();
    step();
    chk("t3 beat count", out_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (out_log.size() > k) chk("t3 beat data", out_log[k], 32'hC0 + k);
    end

    // All sources requesting: strict round robin from source 0.
    do_reset();
    sop_order.delete();
    g_mode = 2;
    repeat (30) begin
      gen_drive();
      step();
      gen_advance();
    end
    chk("t2 packet count ok", sop_order.size() >= 8, 1);
    for (int k = 0; k < 8; k++) begin
      if (sop_order.size() > k) chk("t2 rr order", sop_order[k], k % 4);
    end
    g_mode = 0;

    // Reset on beat 2 of a 4-beat packet from source 0.
    do_reset();
    put(0, 1, 1, 0, 32'hD0);
    step();
    step();
    put(0, 1, 0, 0, 32'hD1);
    #1;
    chk("t5 pre-reset out_valid", ov, 1);
    rst = 1;
    #1;
    chk("t5 reset out_valid", ov, 0);
    chk("t5 reset out_data", od, 0);
    chk("t5 reset out_eop", oe, 0);
    step();
    rst = 0;
    for (int k = 1; k < 4; k++) begin
      put(0, 1, 0, k == 3, 32'hD0 + k);
      step();
      chk("t5 orphan drop", cap_drop[0], 1);
      chk("t5 orphan out_valid", cap_ov, 0);
    end
    clear_inputs();

    // Randomized traffic with random backpressure.
    do_reset();
    g_mode = 1;
    sb_on  = 1;
    repeat (1500) begin
      ordy = ($urandom_range(0, 3) != 0);
      gen_drive();
      step();
      gen_advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
